fast2slow_fifo: RTL
===================

// Module: fast2slow_fifo
// PURPOSE
//  Same-clock fast-to-slow AXI-Stream rate adapter with a DEPTH-entry FIFO. It runs on the fast clock.
//  Output beats may change only on the sample edge, the cycle where clk_cnt == SAMPLE_EDGE_IDX.
//  It sits between a fast-domain producer and a slow-domain consumer in channel bounding.
//  It generalises the single-entry fast2slow buffer: configurable depth, occupancy report, and an
//  optional store-and-forward packet mode.
// PARAMETERS
//  DWIDTH           128        data width in bits, multiple of 8
//  RATIO            2          fast/slow clock ratio, >= 2
//  DEPTH            4          FIFO entries, power of 2, >= 2
//  PKT_MODE         0          0: cut-through with bypass; 1: store-and-forward per tlast packet
//  SAMPLE_EDGE_IDX  RATIO-1    clk_cnt value marking the slow-domain sample edge, < RATIO
// PORTS
//  clk            in   1                   fast clock
//  rst_n          in   1                   asynchronous, active-low reset
//  clk_cnt        in   $clog2(RATIO)       phase of clk within the slow period
//  s_axis_tdata   in   DWIDTH              input data
//  s_axis_tkeep   in   DWIDTH/8            input byte enables
//  s_axis_tlast   in   1                   input end of packet
//  s_axis_tvalid  in   1                   input valid
//  s_axis_tready  out  1                   input ready
//  m_axis_tdata   out  DWIDTH              output data, registered
//  m_axis_tkeep   out  DWIDTH/8            output byte enables, registered
//  m_axis_tlast   out  1                   output end of packet, registered
//  m_axis_tvalid  out  1                   output valid, registered
//  m_axis_tready  in   1                   output ready; sampled only on sample edges
//  fill_level     out  $clog2(DEPTH+1)     FIFO entries in use; excludes the output register
// BEHAVIOUR
//  - Reset (rst_n low, async): pointers, fill_level, pkt_cnt and in_pkt clear; all m_axis_* outputs = 0.
//    s_axis_tready = 0 while in reset; a flag that resets to 0 raises it 1 cycle after rst_n deasserts.
//    A reset mid-packet discards all buffered beats; no partial packet is emitted afterwards.
//  - Definitions:
//    se = (clk_cnt == SAMPLE_EDGE_IDX).
//    ofree = ~m_axis_tvalid | m_axis_tready.
//    full = (fill_level == DEPTH).
//    s_axis_tready = ~full & ready_flag (combinational).
//  - Pop and output load happen only on se & ofree, in this priority order:
//    1. FIFO non-empty and release allowed: head goes to m_axis_*, tvalid <= 1, head is popped.
//    2. PKT_MODE=0, FIFO empty, s_axis_tvalid: the s beat goes directly to m_axis_* (bypass);
//       the beat is consumed and not written to the FIFO.
//    3. Otherwise: m_axis_tvalid <= 0.
//  - If se & ~ofree, or if ~se, m_axis_* hold their values.
//  - Push: s_axis_tvalid & s_axis_tready & ~bypass writes the beat at the write pointer.
//    Push and pop in the same cycle leave fill_level unchanged.
//    Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally; the MSB distinguishes full from empty.
//  - Release allowed:
//    PKT_MODE=0: always.
//    PKT_MODE=1: (pkt_cnt != 0) | full | in_pkt.
//    A packet longer than DEPTH starts draining at full; after that, in_pkt keeps it draining.
//  - pkt_cnt counts complete packets held in the FIFO: +1 on push with tlast, -1 on pop with tlast,
//    net 0 when both happen in the same cycle. Width is $clog2(DEPTH+1).
//  - in_pkt: set on a pop with tlast=0, cleared on a pop with tlast=1.
//  - Latency, PKT_MODE=0:
//    A beat accepted on an se cycle with the FIFO empty appears on m_axis the next clk cycle.
//    Any other beat appears on m_axis after the first se cycle on which it is at the FIFO head and ofree holds.
//  - Beats leave in the order they were accepted; tkeep and tlast travel with their beat unchanged.
//  - Throughput: at most one output beat per slow period. The input sustains RATIO beats per slow
//    period only while the FIFO has room.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles with s_axis_tvalid=1 ->
//    m_axis_tvalid=0, fill_level=0, s_axis_tready=0 during reset; tready=1 one cycle after release.
//  - Bypass: RATIO=2, FIFO empty; drive beat 0xA5 on an se cycle ->
//    m_axis_tdata=0xA5 and tvalid=1 on the next cycle; fill_level stays 0.
//  - Fill to full: DEPTH=4, m_axis_tready=0, stream beats 1..6 ->
//    m_axis holds beat 1; fill_level reaches 4; s_axis_tready=0.
//    Raise tready -> output 2,3,4,5,6 in order, one beat per se.
//  - Simultaneous push/pop: fill_level=2, push on an se cycle that also pops -> fill_level stays 2.
//    Run >2*DEPTH beats to exercise pointer wrap; order is preserved.
//  - PKT_MODE=1: 3-beat packet with a 20-cycle gap before tlast ->
//    m_axis_tvalid=0 until tlast is pushed; then 3 beats on consecutive se cycles.
//  - PKT_MODE=1, DEPTH=4: 7-beat packet ->
//    draining starts at full; all 7 beats are emitted in order with tlast on beat 7.
//    Assert rst_n low mid-packet -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/fast2slow_fifo.sv
// -----------------------------------------------------------------------------
// fast2slow_fifo
//   Rate adapter that runs entirely on the fast clock. It feeds a consumer that
//   only looks at the stream on the slow-domain sample edge
//   (clk_cnt == SAMPLE_EDGE_IDX). A DEPTH-entry FIFO absorbs fast-side bursts.
//   The output register only changes on sample edges.
//   PKT_MODE=0 : cut-through. An empty FIFO lets a beat bypass straight into
//                the output register.
//   PKT_MODE=1 : store-and-forward. Draining starts once a whole packet is
//                buffered, or the FIFO is full (oversized packet). Draining
//                then continues until that packet's tlast leaves.
//
// Ports
//   clk, rst_n           fast clock, async active-low reset
//   clk_cnt              phase of clk within the slow period
//   s_axis_*             fast-side input stream (tready is combinational)
//   m_axis_*             slow-side output stream (registered)
//   m_axis_tready        only meaningful on sample edges
//   fill_level           FIFO entries in use, output register not included
// -----------------------------------------------------------------------------
module fast2slow_fifo #(
  parameter int DWIDTH          = 128,
  parameter int RATIO           = 2,
  parameter int DEPTH           = 4,
  parameter int PKT_MODE        = 0,
  parameter int SAMPLE_EDGE_IDX = RATIO - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(RATIO)-1:0]     clk_cnt,
  input  logic [DWIDTH-1:0]            s_axis_tdata,
  input  logic [DWIDTH/8-1:0]          s_axis_tkeep,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [DWIDTH-1:0]            m_axis_tdata,
  output logic [DWIDTH/8-1:0]          m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int KW = DWIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;            // extra MSB separates full from empty
  localparam int FW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(RATIO);
  localparam int BW = DWIDTH + KW + 1;   // {tlast, tkeep, tdata}
  localparam logic [CW-1:0] SE_IDX = CW'(SAMPLE_EDGE_IDX);

  logic [BW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [FW-1:0]     r_pkt_cnt;
  logic              r_in_pkt;
  logic              r_rdy;
  logic [DWIDTH-1:0] r_tdata;
  logic [KW-1:0]     r_tkeep;
  logic              r_tlast;
  logic              r_tvalid;

  logic [PW-1:0] w_fill;
  logic [BW-1:0] w_head, w_sbeat;
  logic          w_se, w_ofree, w_full, w_empty, w_rel;
  logic          w_pop, w_byp, w_push, w_head_last, w_push_last, w_pop_last;

  assign w_fill      = r_wptr - r_rptr;
  assign w_full      = (w_fill == PW'(DEPTH));
  assign w_empty     = (r_wptr == r_rptr);
  assign w_se        = (clk_cnt == SE_IDX);
  assign w_ofree     = ~r_tvalid | m_axis_tready;
  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign w_head_last = w_head[BW-1];
  assign w_sbeat     = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  // Store-and-forward holds the FIFO until a packet is complete. Two cases
  // force it to drain anyway: the FIFO is full (a packet larger than DEPTH),
  // or a packet has already started leaving.
  assign w_rel = (PKT_MODE == 0) ? 1'b1
                                 : ((r_pkt_cnt != '0) | w_full | r_in_pkt);

  assign s_axis_tready = ~w_full & r_rdy;

  assign w_pop  = w_se & w_ofree & ~w_empty & w_rel;
  // Bypass only when nothing is queued, so beat order is preserved.
  assign w_byp  = (PKT_MODE == 0) & w_se & w_ofree & w_empty
                  & s_axis_tvalid & s_axis_tready;
  assign w_push = s_axis_tvalid & s_axis_tready & ~w_byp;

  assign w_push_last = w_push & s_axis_tlast;
  assign w_pop_last  = w_pop  & w_head_last;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_sbeat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pkt_cnt <= '0;
      r_in_pkt  <= 1'b0;
      r_rdy     <= 1'b0;
      r_tdata   <= '0;
      r_tkeep   <= '0;
      r_tlast   <= 1'b0;
      r_tvalid  <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (w_push) r_wptr <= r_wptr + PW'(1);

      if (w_pop) begin
        r_rptr                      <= r_rptr + PW'(1);
        {r_tlast, r_tkeep, r_tdata} <= w_head;
        r_tvalid                    <= 1'b1;
        r_in_pkt                    <= ~w_head_last;
      end else if (w_byp) begin
        {r_tlast, r_tkeep, r_tdata} <= w_sbeat;
        r_tvalid                    <= 1'b1;
      end else if (w_se & w_ofree) begin
        r_tvalid <= 1'b0;
      end

      if (w_push_last & ~w_pop_last)      r_pkt_cnt <= r_pkt_cnt + FW'(1);
      else if (~w_push_last & w_pop_last) r_pkt_cnt <= r_pkt_cnt - FW'(1);
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;
  assign fill_level    = FW'(w_fill);

endmodule
